// File: rtl/mmio_if_pio_irq.sv
// mmio_if_pio_irq: Avalon-MM input PIO with synchroniser, sticky edge capture and maskable irq.
// Optional per-bit debounce filter enabled by defining PIO_DEBOUNCE_EN.
module mmio_if_pio_irq #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] s_raw, s_out, prev_q, mask_q, mask_d, ec_q, ec_d, ev, clr;
  logic [2:0]       arm_cnt_q, arm_cnt_d;
  logic             armed_q, armed_d, irq_d, wr;
  logic [31:0]      rd_d;
  logic             wd_unused;
  assign wd_unused = &{1'b0, writedata};
  assign s_raw     = sync_q[SYNC_STAGES-1];
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], in_port};
`ifdef PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0]         filt_q, filt_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  // filt follows the raw bit only after it has differed for DEBOUNCE_CYCLES clocks in a row
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s_raw[i] == filt_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d[i] = s_raw[i];
        cnt_d[i]  = '0;
      end else cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  assign s_out = filt_q;
`else
  localparam int DB_UNUSED = DEBOUNCE_CYCLES;
  assign s_out = s_raw;
`endif
  always_comb begin
    wr        = chipselect & ~write_n;
    arm_cnt_d = armed_q ? arm_cnt_q : arm_cnt_q + 3'd1;
    armed_d   = armed_q | (arm_cnt_q == 3'(SYNC_STAGES));
    // events before arming would come from the synchroniser filling after reset
    ev        = !armed_q        ? '0 :
                EDGE_TYPE == 1  ? ~s_out & prev_q :
                EDGE_TYPE == 2  ? s_out ^ prev_q :
                                  s_out & ~prev_q;
    clr       = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    ec_d      = (ec_q & ~clr) | ev;
    mask_d    = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    irq_d     = |(ec_d & mask_q);
    rd_d      = address == 2'd0 ? 32'(s_out)  :
                address == 2'd2 ? 32'(mask_q) :
                address == 2'd3 ? 32'(ec_q)   : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q    <= '0;
      prev_q    <= '0;
      mask_q    <= '0;
      ec_q      <= '0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= s_out;
      mask_q    <= mask_d;
      ec_q      <= ec_d;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
      irq       <= irq_d;
      readdata  <= rd_d;
    end
endmodule
